// File: rtl/flag_branch_unit.sv
// Flag register, branch condition evaluation and program counter sequencing.
// A taken branch redirects the pc and spends one FLUSH cycle before resuming.
module flag_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flagWrite,
  input  logic        carryFlag,
  input  logic        zFlag,
  input  logic        signFlag,
  input  logic        overflowFlag,
  input  logic        brValid,
  input  logic [3:0]  brCode,
  input  logic [31:0] brTarget,
  input  logic [31:0] regVal,
  output logic [31:0] pc,
  output logic        flush,
  output logic        linkWrite,
  output logic [31:0] linkAddr,
  output logic [3:0]  flagsOut,
  output logic        illegal
);

  typedef enum logic {
    RUN,
    FLUSH
  } stateT;

  localparam logic [3:0] CODE_CALL = 4'd10;

  stateT       state;
  logic        condTrue;
  logic        codeLegal;
  logic        taken;
  logic [31:0] pcPlus4;
  logic        unusedTargetBits;

  // Stored flag layout is {C,Z,S,V}; conditions see only the registered
  // copy, so a flagWrite in the same cycle does not influence the branch.
  always_comb begin
    condTrue  = 1'b0;
    codeLegal = 1'b1;
    case (brCode)
      4'd0:    condTrue = 1'b1;
      4'd1:    condTrue = regVal[31];
      4'd2:    condTrue = (regVal == 32'd0);
      4'd3:    condTrue = (regVal != 32'd0);
      4'd4:    condTrue = flagsOut[3];
      4'd5:    condTrue = ~flagsOut[3];
      4'd6:    condTrue = flagsOut[1];
      4'd7:    condTrue = ~flagsOut[1];
      4'd8:    condTrue = flagsOut[0];
      4'd9:    condTrue = ~flagsOut[0];
      4'd10:   condTrue = 1'b1;
      4'd11:   condTrue = 1'b1;
      default: codeLegal = 1'b0;
    endcase
  end

  assign taken            = brValid & codeLegal & condTrue;
  assign pcPlus4          = pc + 32'd4;
  assign unusedTargetBits = ^brTarget[1:0];

  // Pulses default low every unstalled cycle; only a RUN-state decision can
  // raise them, and RUN is always followed by FLUSH after a taken branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= 32'd0;
      flagsOut  <= 4'd0;
      flush     <= 1'b0;
      linkWrite <= 1'b0;
      linkAddr  <= 32'd0;
      illegal   <= 1'b0;
    end else if (stall) begin
      flush     <= 1'b0;
      linkWrite <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          flush     <= taken;
          linkWrite <= taken && (brCode == CODE_CALL);
          illegal   <= brValid & ~codeLegal;
          if (flagWrite)
            flagsOut <= {carryFlag, zFlag, signFlag, overflowFlag};
          if (taken) begin
            pc    <= {brTarget[31:2], 2'b00};
            state <= FLUSH;
            if (brCode == CODE_CALL)
              linkAddr <= pcPlus4;
          end else begin
            pc <= pcPlus4;
          end
        end
        FLUSH: begin
          pc        <= pcPlus4;
          flush     <= 1'b0;
          linkWrite <= 1'b0;
          illegal   <= 1'b0;
          state     <= RUN;
        end
      endcase
    end
  end

endmodule
